udma_eth_rx_frame_filter: RTL

- Cut-through receive filter in the eth_clk_i domain, between the Ethernet MAC receive AXI-stream and the uDMA RX data buffer.
- Its master output is the stream the RX controller's packet-size monitor observes.
- Drops runts and frames whose destination MAC does not match. Truncates oversize frames. Reports bad-FCS frames.
- Every frame leaving the block therefore carries exactly one tlast and a length in [6, MAX_FRAME_LEN].

---
 rtl/udma_eth_rx_frame_filter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/udma_eth_rx_frame_filter.sv
// udma_eth_rx_frame_filter
//
// Cut-through receive filter between the Ethernet MAC receive stream and the
// uDMA RX data buffer (eth_clk_i domain). The six destination-MAC bytes are
// buffered, checked against the station address, and then either replayed
// to the master port or thrown away. After the replay, the rest of the frame
// passes through combinationally. The block drops runts and address
// mismatches. It truncates frames longer than MAX_FRAME_LEN with a forced
// tlast. Every frame on the master port has exactly one tlast and a length
// in [6, MAX_FRAME_LEN].
//
// Ports
//   eth_clk_i, eth_rstn_i      clock, asynchronous active-low reset
//   cfg_mac_addr_i             station MAC, [47:40] is the first byte on wire
//   cfg_promisc_i              accept every destination
//   cfg_bcast_en_i             accept FF:FF:FF:FF:FF:FF
//   s_axis_*                   MAC receive byte stream (tuser = bad frame)
//   m_axis_*                   filtered byte stream towards the RX buffer
//   drop_cnt_o                 frames discarded (runt or address mismatch)
//   trunc_cnt_o                frames truncated at MAX_FRAME_LEN
//   err_event_o                pulse per runt, truncation or bad forwarded frame
//   frame_event_o              pulse per forwarded tlast handshake
module udma_eth_rx_frame_filter #(
    parameter int unsigned MAX_FRAME_LEN = 1518,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 eth_clk_i,
    input  logic                 eth_rstn_i,
    input  logic [47:0]          cfg_mac_addr_i,
    input  logic                 cfg_promisc_i,
    input  logic                 cfg_bcast_en_i,
    input  logic [7:0]           s_axis_tdata_i,
    input  logic                 s_axis_tvalid_i,
    input  logic                 s_axis_tlast_i,
    input  logic                 s_axis_tuser_i,
    output logic                 s_axis_tready_o,
    output logic [7:0]           m_axis_tdata_o,
    output logic                 m_axis_tvalid_o,
    output logic                 m_axis_tlast_o,
    input  logic                 m_axis_tready_i,
    output logic [CNT_WIDTH-1:0] drop_cnt_o,
    output logic [CNT_WIDTH-1:0] trunc_cnt_o,
    output logic                 err_event_o,
    output logic                 frame_event_o
);

    localparam int unsigned DATA_W = 8;
    // bcnt value of the forwarded byte that is numbered MAX_FRAME_LEN.
    localparam logic [10:0] LAST_BYTE_IDX = 11'(MAX_FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DECIDE,
        ST_REPLAY,
        ST_PASS,
        ST_DISCARD
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hdr_q [6];
    logic [10:0]         bcnt_q, bcnt_d;
    logic [2:0]          idx_q, idx_d;
    logic                hdr_last_q, hdr_last_d;
    logic                hdr_bad_q, hdr_bad_d;
    logic                drop_inc, trunc_inc, err_d, frame_d;
    logic                s_ready_int;
    logic                s_hs, m_hs;
    logic [47:0]         dest;
    logic                match;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign dest  = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
    assign match = cfg_promisc_i
                 | (cfg_bcast_en_i & (dest == 48'hFFFF_FFFF_FFFF))
                 | (dest == cfg_mac_addr_i);

    // Ready is also gated by the raw reset so that no byte is taken while reset is held.
    assign s_axis_tready_o = eth_rstn_i & s_ready_int;
    assign s_hs            = s_axis_tvalid_i & s_axis_tready_o;
    assign m_hs            = m_axis_tvalid_o & m_axis_tready_i;

    always_comb begin
        s_ready_int     = 1'b0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = '0;
        m_axis_tlast_o  = 1'b0;
        case (state_q)
            ST_HDR, ST_DISCARD: s_ready_int = 1'b1;
            ST_REPLAY: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = hdr_q[idx_q];
                m_axis_tlast_o  = hdr_last_q & (idx_q == 3'd5);
            end
            ST_PASS: begin
                s_ready_int     = m_axis_tready_i;
                m_axis_tvalid_o = s_axis_tvalid_i;
                m_axis_tdata_o  = s_axis_tdata_i;
                // A forced tlast on the MAX_FRAME_LEN-th byte makes the frame a truncation.
                m_axis_tlast_o  = s_axis_tlast_i | (bcnt_q == LAST_BYTE_IDX);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        idx_d      = idx_q;
        hdr_last_d = hdr_last_q;
        hdr_bad_d  = hdr_bad_q;
        drop_inc   = 1'b0;
        trunc_inc  = 1'b0;
        err_d      = 1'b0;
        frame_d    = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (s_hs) begin
                    if (bcnt_q == 11'd5) begin
                        hdr_last_d = s_axis_tlast_i;
                        hdr_bad_d  = s_axis_tuser_i;
                        bcnt_d     = 11'd6;
                        state_d    = ST_DECIDE;
                    end else if (s_axis_tlast_i) begin
                        drop_inc = 1'b1;
                        err_d    = 1'b1;
                        bcnt_d   = '0;
                    end else begin
                        bcnt_d = bcnt_q + 11'd1;
                    end
                end
            end
            ST_DECIDE: begin
                idx_d = '0;
                if (match) begin
                    state_d = ST_REPLAY;
                end else begin
                    drop_inc = 1'b1;
                    if (hdr_last_q) begin
                        state_d = ST_HDR;
                        bcnt_d  = '0;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_REPLAY: begin
                if (m_hs) begin
                    if (idx_q == 3'd5) begin
                        if (hdr_last_q) begin
                            state_d = ST_HDR;
                            bcnt_d  = '0;
                            frame_d = 1'b1;
                            err_d   = hdr_bad_q;
                        end else begin
                            state_d = ST_PASS;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PASS: begin
                if (s_hs) begin
                    bcnt_d = bcnt_q + 11'd1;
                    if (s_axis_tlast_i) begin
                        state_d = ST_HDR;
                        bcnt_d  = '0;
                        frame_d = 1'b1;
                        err_d   = s_axis_tuser_i;
                    end else if (bcnt_q == LAST_BYTE_IDX) begin
                        state_d   = ST_DISCARD;
                        trunc_inc = 1'b1;
                        err_d     = 1'b1;
                        frame_d   = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (s_hs && s_axis_tlast_i) begin
                    state_d = ST_HDR;
                    bcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_HDR;
                bcnt_d  = '0;
            end
        endcase
    end

    // ---- control stage: state, counters, event pulses ----
    always_ff @(posedge eth_clk_i or negedge eth_rstn_i) begin
        if (!eth_rstn_i) begin
            state_q       <= ST_HDR;
            bcnt_q        <= '0;
            idx_q         <= '0;
            hdr_last_q    <= 1'b0;
            hdr_bad_q     <= 1'b0;
            drop_cnt_o    <= '0;
            trunc_cnt_o   <= '0;
            err_event_o   <= 1'b0;
            frame_event_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            idx_q         <= idx_d;
            hdr_last_q    <= hdr_last_d;
            hdr_bad_q     <= hdr_bad_d;
            err_event_o   <= err_d;
            frame_event_o <= frame_d;
            if (drop_inc)  drop_cnt_o  <= sat_inc(drop_cnt_o);
            if (trunc_inc) trunc_cnt_o <= sat_inc(trunc_cnt_o);
        end
    end

    // ---- header capture stage: data only, no reset needed ----
    always_ff @(posedge eth_clk_i) begin
        if (state_q == ST_HDR && s_hs) hdr_q[bcnt_q[2:0]] <= s_axis_tdata_i;
    end

endmodule
